atmos_light_est: RTL and testbench

Per-frame atmospheric-light estimator for the haze-removal pipeline. It sits directly downstream of the dark-channel stage and consumes its 8-bit dark-channel stream together with the pixel-aligned original RGB stream. Over each frame it finds the RGB value at the brightest dark-channel pixel, clamps and optionally temporally smooths it, and holds the resulting atmospheric light A stable for the transmission and recovery stages of the next frame.

---
 rtl/atmos_light_est.sv | 168 ++++++++++++++++
 tb/tb_atmos_light_est.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmos_light_est.sv
// Per-frame atmospheric light estimator: tracks the RGB of the brightest
// dark-channel pixel, clamps it, optionally blends it, and holds A per frame.
module atmos_light_est #(
  parameter int unsigned A_MAX     = 220,
  parameter int unsigned A_INIT    = 220,
  parameter bit          SMOOTH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  input  logic [7:0]  pre_dark,
  input  logic [23:0] pre_rgb,
  output logic [7:0]  atmos_r,
  output logic [7:0]  atmos_g,
  output logic [7:0]  atmos_b,
  output logic [7:0]  atmos_gray,
  output logic        atmos_valid,
  output logic        atmos_locked
);

  localparam logic [7:0] AMAX8 = 8'(A_MAX);
  localparam logic [7:0] AINI8 = 8'(A_INIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CALC,
    OUT
  } state_e;

  state_e      state_q;
  logic        vsync_q;
  logic        pend_q;
  logic [7:0]  max_q;
  logic [23:0] cand_q;
  logic [21:0] cnt_q;
  logic [7:0]  c_r_q, c_g_q, c_b_q;
  logic [7:0]  a_r_q, a_g_q, a_b_q;
  logic [7:0]  gray_q;
  logic        valid_q;
  logic        locked_q;

  logic        rise, fall, pix, take;
  logic [7:0]  a_r_d, a_g_d, a_b_d, gray_d;

  function automatic logic [7:0] clamp(
    input logic [7:0] v
  );
    return (v > AMAX8) ? AMAX8 : v;
  endfunction

  // (3*old + new + 2) >> 2; both inputs <= A_MAX keeps the result <= A_MAX
  function automatic logic [7:0] blend(
    input logic [7:0] o,
    input logic [7:0] n
  );
    logic [9:0] s;
    s = 10'(o) + 10'(o) + 10'(o) + 10'(n) + 10'd2;
    return s[9:2];
  endfunction

  assign rise = pre_frame_vsync & ~vsync_q;
  assign fall = ~pre_frame_vsync & vsync_q;
  assign pix  = pre_frame_vsync & pre_frame_href
              & pre_frame_clken;
  assign take = (cnt_q == '0) || (pre_dark > max_q);

  always_comb begin
    a_r_d = c_r_q;
    a_g_d = c_g_q;
    a_b_d = c_b_q;
    if (SMOOTH_EN && locked_q) begin
      a_r_d = blend(a_r_q, c_r_q);
      a_g_d = blend(a_g_q, c_g_q);
      a_b_d = blend(a_b_q, c_b_q);
    end
    gray_d = a_r_d;
    if (a_g_d > gray_d) gray_d = a_g_d;
    if (a_b_d > gray_d) gray_d = a_b_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      pend_q   <= 1'b0;
      max_q    <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      c_r_q    <= '0;
      c_g_q    <= '0;
      c_b_q    <= '0;
      a_r_q    <= AINI8;
      a_g_q    <= AINI8;
      a_b_q    <= AINI8;
      gray_q   <= AINI8;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      vsync_q <= pre_frame_vsync;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q  <= 1'b0;
            max_q   <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end else if (rise) begin
            state_q <= ACCUM;
            if (pix) begin
              max_q  <= pre_dark;
              cand_q <= pre_rgb;
              cnt_q  <= 22'd1;
            end else begin
              max_q  <= '0;
              cand_q <= '0;
              cnt_q  <= '0;
            end
          end
        end
        ACCUM: begin
          if (pix) begin
            if (take) begin
              max_q  <= pre_dark;
              cand_q <= pre_rgb;
            end
            if (cnt_q != '1) cnt_q <= cnt_q + 22'd1;
          end
          if (fall) state_q <= CALC;
        end
        CALC: begin
          if (rise) pend_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            c_r_q   <= clamp(cand_q[23:16]);
            c_g_q   <= clamp(cand_q[15:8]);
            c_b_q   <= clamp(cand_q[7:0]);
            state_q <= OUT;
          end
        end
        OUT: begin
          if (rise) pend_q <= 1'b1;
          a_r_q    <= a_r_d;
          a_g_q    <= a_g_d;
          a_b_q    <= a_b_d;
          gray_q   <= gray_d;
          valid_q  <= 1'b1;
          locked_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign atmos_r      = a_r_q;
  assign atmos_g      = a_g_q;
  assign atmos_b      = a_b_q;
  assign atmos_gray   = gray_q;
  assign atmos_valid  = valid_q;
  assign atmos_locked = locked_q;

endmodule

// File: tb/tb_atmos_light_est.sv
// Bench for atmos_light_est: directed frames plus random frames
// checked against a per-frame reference model.
module tb_atmos_light_est;

  logic        clk;
  logic        rst_n;
  logic        vs, hr, ce;
  logic [7:0]  dk;
  logic [23:0] rgb;
  logic [7:0]  ar, ag, ab, agray;
  logic        avalid, alocked;

  int checks;
  int failures;

  logic [7:0]  fd[$];
  logic [23:0] fr[$];
  int          mA[3];
  bit          mlk;
  logic [4:0]  vp;

  atmos_light_est #(
    .A_MAX(220),
    .A_INIT(220),
    .SMOOTH_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pre_frame_vsync(vs),
    .pre_frame_href(hr),
    .pre_frame_clken(ce),
    .pre_dark(dk),
    .pre_rgb(rgb),
    .atmos_r(ar),
    .atmos_g(ag),
    .atmos_b(ab),
    .atmos_gray(agray),
    .atmos_valid(avalid),
    .atmos_locked(alocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    vs = 0; hr = 0; ce = 0; dk = 0; rgb = 0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    mA[0] = 220; mA[1] = 220; mA[2] = 220;
    mlk = 0;
  endtask

  task automatic push(input int d, input int r,
                      input int g, input int b);
    fd.push_back(8'(d));
    fr.push_back({8'(r), 8'(g), 8'(b)});
  endtask

  task automatic play_frame(input int gmax);
    int g;
    vs = 1;
    for (int i = 0; i < fd.size(); i++) begin
      g = $urandom_range(0, gmax);
      repeat (g) begin
        hr = 1'($urandom_range(0, 1));
        ce = ~hr;
        dk = 8'hff;
        rgb = 24'($urandom);
        tick;
      end
      hr = 1; ce = 1; dk = fd[i]; rgb = fr[i];
      tick;
    end
    hr = 0; ce = 0;
    tick;
    vs = 0;
  endtask

  task automatic end_frame(output logic [4:0] v);
    v = '0;
    for (int k = 0; k < 5; k++) begin
      tick;
      v[k] = avalid;
    end
  endtask

  // Reference: strict-greater scan keeps first max; clamp; blend if locked
  task automatic model_frame;
    int bd, c, ch;
    logic [23:0] best;
    bd = -1;
    best = '0;
    for (int i = 0; i < fd.size(); i++)
      if (int'(fd[i]) > bd) begin
        bd = int'(fd[i]);
        best = fr[i];
      end
    if (fd.size() == 0) return;
    for (int k = 0; k < 3; k++) begin
      ch = int'((best >> (8 * (2 - k))) & 24'hff);
      c = (ch > 220) ? 220 : ch;
      mA[k] = mlk ? (3 * mA[k] + c + 2) / 4 : c;
    end
    mlk = 1;
  endtask

  function automatic int mgray;
    int m;
    m = mA[0];
    if (mA[1] > m) m = mA[1];
    if (mA[2] > m) m = mA[2];
    return m;
  endfunction

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({ar, ag, ab} !== {3{8'd220}}) begin
      failures++;
      $display("FAIL reset_A got=%h want=%h", {ar, ag, ab}, {3{8'd220}});
    end
    checks++;
    if ({agray, avalid, alocked} !== {8'd220, 2'b00}) begin
      failures++;
      $display("FAIL reset_flags got=%h/%b/%b want=dc/0/0",
               agray, avalid, alocked);
    end
  endtask

  task automatic test_single_max;
    apply_reset;
    fd.delete(); fr.delete();
    for (int i = 0; i < 16; i++)
      if (i == 9) push(200, 230, 210, 205);
      else push(10, $urandom_range(0, 255), 7, 7);
    play_frame(1);
    end_frame(vp);
    checks++;
    if (vp !== 5'b00100) begin
      failures++;
      $display("FAIL single_valid got=%b want=00100", vp);
    end
    checks++;
    if ({ar, ag, ab} !== {8'd220, 8'd210, 8'd205}) begin
      failures++;
      $display("FAIL single_A got=%0d,%0d,%0d want=220,210,205",
               ar, ag, ab);
    end
    checks++;
    if ({agray, alocked} !== {8'd220, 1'b1}) begin
      failures++;
      $display("FAIL single_gray got=%0d/%b want=220/1", agray, alocked);
    end
  endtask

  task automatic test_tie;
    apply_reset;
    fd.delete(); fr.delete();
    for (int i = 0; i < 16; i++)
      if (i == 3) push(150, 90, 80, 70);
      else if (i == 11) push(150, 120, 120, 120);
      else push($urandom_range(0, 149), 200, 200, 200);
    play_frame(2);
    end_frame(vp);
    checks++;
    if ({ar, ag, ab} !== {8'd90, 8'd80, 8'd70}) begin
      failures++;
      $display("FAIL tie_A got=%0d,%0d,%0d want=90,80,70", ar, ag, ab);
    end
  endtask

  task automatic test_smooth;
    apply_reset;
    fd.delete(); fr.delete();
    for (int i = 0; i < 16; i++)
      if (i == 5) push(99, 100, 100, 100);
      else push(20, 9, 9, 9);
    play_frame(0);
    end_frame(vp);
    checks++;
    if ({ar, ag, ab, vp} !== {{3{8'd100}}, 5'b00100}) begin
      failures++;
      $display("FAIL smooth_f1 got=%0d,%0d,%0d v=%b want=100 v=00100",
               ar, ag, ab, vp);
    end
    fd.delete(); fr.delete();
    for (int i = 0; i < 16; i++)
      if (i == 0) push(180, 200, 200, 200);
      else push(30, 5, 5, 5);
    play_frame(1);
    end_frame(vp);
    checks++;
    if ({ar, ag, ab, agray} !== {4{8'd125}}) begin
      failures++;
      $display("FAIL smooth_f2 got=%0d,%0d,%0d g=%0d want=125",
               ar, ag, ab, agray);
    end
  endtask

  task automatic test_empty;
    apply_reset;
    vs = 1; hr = 1; ce = 0; dk = 8'hff; rgb = 24'h102030;
    repeat (20) tick;
    vs = 0; hr = 0;
    end_frame(vp);
    checks++;
    if (vp !== 5'b00000) begin
      failures++;
      $display("FAIL empty_valid got=%b want=00000", vp);
    end
    checks++;
    if ({ar, ag, ab, alocked} !== {{3{8'd220}}, 1'b0}) begin
      failures++;
      $display("FAIL empty_A got=%0d,%0d,%0d l=%b want=220 l=0",
               ar, ag, ab, alocked);
    end
  endtask

  task automatic test_midframe_reset;
    apply_reset;
    fd.delete(); fr.delete();
    push(50, 100, 100, 100);
    play_frame(0);
    end_frame(vp);
    vs = 1; hr = 1; ce = 1; dk = 255; rgb = {8'd50, 8'd60, 8'd70};
    tick;
    ce = 0;
    tick;
    rst_n = 0;
    #1;
    checks++;
    if ({ar, ag, ab, avalid, alocked} !== {{3{8'd220}}, 2'b00}) begin
      failures++;
      $display("FAIL midrst_out got=%0d,%0d,%0d v=%b l=%b want=220 0 0",
               ar, ag, ab, avalid, alocked);
    end
    vs = 0; hr = 0;
    tick; tick;
    rst_n = 1;
    end_frame(vp);
    checks++;
    if (vp !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_nopulse got=%b want=00000", vp);
    end
    fd.delete(); fr.delete();
    for (int i = 0; i < 8; i++)
      if (i == 2) push(90, 40, 40, 40);
      else push(3, 1, 1, 1);
    play_frame(1);
    end_frame(vp);
    checks++;
    if ({ar, ag, ab, vp} !== {{3{8'd40}}, 5'b00100}) begin
      failures++;
      $display("FAIL midrst_next got=%0d,%0d,%0d v=%b want=40 v=00100",
               ar, ag, ab, vp);
    end
  endtask

  task automatic test_zero_dark;
    apply_reset;
    fd.delete(); fr.delete();
    push(0, 1, 2, 3);
    for (int i = 1; i < 16; i++)
      push(0, $urandom_range(0, 255), 200, 200);
    play_frame(0);
    end_frame(vp);
    checks++;
    if ({ar, ag, ab, agray} !== {8'd1, 8'd2, 8'd3, 8'd3}) begin
      failures++;
      $display("FAIL zero_A got=%0d,%0d,%0d g=%0d want=1,2,3 g=3",
               ar, ag, ab, agray);
    end
  endtask

  task automatic test_random;
    int n;
    logic [4:0] ev;
    apply_reset;
    for (int f = 0; f < 10; f++) begin
      fd.delete(); fr.delete();
      n = (f == 4) ? 0 : $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        push($urandom_range(0, 15), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255));
      play_frame(3);
      model_frame;
      end_frame(vp);
      ev = (n == 0) ? 5'b00000 : 5'b00100;
      checks++;
      if (vp !== ev) begin
        failures++;
        $display("FAIL rand_valid f=%0d got=%b want=%b", f, vp, ev);
      end
      checks++;
      if ({ar, ag, ab} !== {8'(mA[0]), 8'(mA[1]), 8'(mA[2])}) begin
        failures++;
        $display("FAIL rand_A f=%0d got=%0d,%0d,%0d want=%0d,%0d,%0d",
                 f, ar, ag, ab, mA[0], mA[1], mA[2]);
      end
      checks++;
      if ({agray, alocked} !== {8'(mgray()), mlk}) begin
        failures++;
        $display("FAIL rand_gray f=%0d got=%0d/%b want=%0d/%b",
                 f, agray, alocked, mgray(), mlk);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_single_max;
    test_tie;
    test_smooth;
    test_empty;
    test_midframe_reset;
    test_zero_dark;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
